cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt controller. It is the consumer end of the per-stage exception fields (PC, BD, ExcCode) carried down the pipeline registers.
- It sits beside the M stage. It samples the M-stage instruction's exception info plus external hardware interrupts.
- It decides whether to take an exception, records EPC/Cause/SR, and drives int_req back to every pipeline register for flush and redirect to 0x0000_4180.
- It also services mfc0/mtc0 accesses and eret (EXL clear).

Parameters:
- PRID, 32'h4255_4141: read-only value of the PrID register (CP0 reg 15).
- HWINT_W, 6: number of hardware interrupt lines. Maps to SR.IM / Cause.IP bits [15:10].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- A  input  5  CP0 register number for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PrID)
- we  input  1  mtc0 write enable (M stage)
- DIn  input  32  mtc0 write data
- PC_in  input  32  M-stage PC
- BD_in  input  1  M-stage instruction is in a delay slot
- ExcCode_in  input  5  M-stage exception code; 0 = no exception
- HWInt  input  HWINT_W  external interrupt lines, level sensitive
- EXL_clr  input  1  eret in M stage
- int_req  output  1  take-exception request (combinational)
- EPC_out  output  32  current EPC register, used as eret target
- DOut  output  32  mfc0 read data (combinational)

Behaviour:
- State elements:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC: 32 bits.
  - PrID: constant PRID.
- Reset (reset low, asynchronous): SR = 0, Cause = 0, EPC = 0. Consequences during reset:
  - int_req = 0, since IE = 0 and EXL = 0 only permits exceptions with ExcCode_in != 0. int_req is forced 0 while reset is low.
  - EPC_out = 0.
- Combinational request:
  - IntReq = IE & ~EXL & |(HWInt & IM)
  - ExcReq = ~EXL & (ExcCode_in != 0)
  - int_req = IntReq | ExcReq
  - Zero latency, same cycle as the M-stage inputs.
- On posedge with int_req = 1 (exception entry):
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_in. Interrupts take priority over synchronous exceptions.
  - Cause.BD <= BD_in.
  - EPC <= (BD_in ? PC_in - 4 : PC_in) with bits [1:0] forced 0. Subtraction is 32-bit modulo, so PC_in = 0 with BD_in = 1 gives 0xFFFF_FFFC.
  - Any mtc0 in the same cycle is discarded, because the instruction is being flushed.
- Otherwise, on posedge:
  - If EXL_clr: EXL <= 0. EXL_clr and int_req cannot both be 1, because EXL gates int_req. If both are forced, entry wins.
  - If we and A = 12: SR <= {DIn[15:10], DIn[1], DIn[0]} into the defined fields.
  - If we and A = 14: EPC <= DIn with bits [1:0] forced 0.
  - If we targets A = 13, A = 15 or an undefined address: no effect.
- Every posedge, independent of other events: Cause.IP <= HWInt.
- Write visibility: a new register value appears on DOut/EPC_out the cycle after the write edge. There is no write-through bypass.
- DOut:
  - A = 12: SR.
  - A = 13: Cause.
  - A = 14: EPC.
  - A = 15: PRID.
  - Any other A: 0.
- Nested exceptions: while EXL = 1, all requests are masked. HWInt still updates Cause.IP.
- EPC_out always reflects the EPC register. The eret redirect uses it directly.

Decomposition:
- Shared package holds:
  - CP0 register numbers (CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15).
  - Exception code constants (EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12).
  - Handler address 32'h0000_4180.
  - SR/Cause bit-field positions.
- One sub-module is natural: cp0_int_arbiter, a combinational block that computes IntReq, ExcReq and the selected ExcCode.
- Register state stays in cp0_exc_unit.

Test Plan:
- Reset low mid-operation with EXL = 1 and EPC = 0x3008 -> SR, Cause and EPC read 0 immediately; int_req = 0.
- mtc0 SR = 0x0000_0401 (IM[10] = 1, IE = 1), then HWInt = 6'b000001 -> int_req = 1 the same cycle. After the edge: EXL = 1, Cause.ExcCode = 0, Cause.IP = 0x01 (Cause = 0x0000_0400), EPC = PC_in.
- ExcCode_in = 10, PC_in = 0x3010, BD_in = 1 -> int_req = 1. After the edge: EPC = 0x300C, Cause = 0x8000_0028.
- Same cycle HWInt enabled and ExcCode_in = 12 -> Cause.ExcCode = 0 (interrupt priority).
- With EXL = 1, apply ExcCode_in = 4 -> int_req = 0. Then EXL_clr for one cycle -> EXL = 0, and int_req = 1 the next cycle.
- mtc0 EPC = 0x0000_3007 together with int_req = 1 -> write dropped, EPC = entry value. Without int_req, a later read gives 0x0000_3004. A read of A = 15 gives PRID.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// Shared constants for the CP0 exception/interrupt controller:
// register numbers, exception codes, the handler address and the
// bit-field positions of the SR and Cause registers.
package cp0_exc_unit_pkg;

  // CP0 register numbers used by mfc0/mtc0.
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes as carried down the pipeline (0 means no exception).
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Redirect target for every exception/interrupt entry.
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // SR fields.
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause fields.
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

endpackage

// File: rtl/cp0_exc_unit_int_arbiter.sv
// cp0_int_arbiter: combinational request logic.
//   ie, exl      : current SR.IE / SR.EXL
//   im, hw_int   : interrupt mask and live hardware interrupt lines
//   exc_code_in  : M-stage exception code (0 = none)
//   int_hw_req   : an enabled hardware interrupt is pending
//   exc_req      : a synchronous exception is pending
//   sel_exc_code : code to record in Cause.ExcCode on entry
module cp0_int_arbiter
  import cp0_exc_unit_pkg::*;
#(
  parameter int HWINT_W = 6
) (
  input  logic               ie,
  input  logic               exl,
  input  logic [HWINT_W-1:0] im,
  input  logic [HWINT_W-1:0] hw_int,
  input  logic [4:0]         exc_code_in,
  output logic               int_hw_req,
  output logic               exc_req,
  output logic [4:0]         sel_exc_code
);

  assign int_hw_req = ie & ~exl & (|(hw_int & im));
  assign exc_req    = ~exl & (exc_code_in != EXC_INT);

  // Interrupts win over a synchronous exception arriving in the same cycle.
  assign sel_exc_code = int_hw_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 exception/interrupt controller beside the M stage.
//   clk, reset  : rising-edge clock, asynchronous active-low reset
//   A, we, DIn  : mfc0/mtc0 register number, write enable, write data
//   PC_in, BD_in, ExcCode_in : M-stage exception info
//   HWInt       : level-sensitive hardware interrupt lines
//   EXL_clr     : eret in M stage
//   int_req     : take-exception request (combinational, flush + redirect)
//   EPC_out     : EPC register, eret target
//   DOut        : mfc0 read data (combinational)
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h4255_4141,
  parameter int          HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A,
  input  logic               we,
  input  logic [31:0]        DIn,
  input  logic [31:0]        PC_in,
  input  logic               BD_in,
  input  logic [4:0]         ExcCode_in,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXL_clr,
  output logic               int_req,
  output logic [31:0]        EPC_out,
  output logic [31:0]        DOut
);

  // Architectural state.
  logic [HWINT_W-1:0] sr_im_q, sr_im_d;
  logic               sr_exl_q, sr_exl_d;
  logic               sr_ie_q, sr_ie_d;
  logic               cause_bd_q, cause_bd_d;
  logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]         cause_exc_q, cause_exc_d;
  logic [31:0]        epc_q, epc_d;

  logic        int_hw_req;
  logic        exc_req;
  logic [4:0]  sel_exc_code;
  logic [31:0] epc_entry;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  cp0_int_arbiter #(.HWINT_W(HWINT_W)) u_arbiter (
    .ie           (sr_ie_q),
    .exl          (sr_exl_q),
    .im           (sr_im_q),
    .hw_int       (HWInt),
    .exc_code_in  (ExcCode_in),
    .int_hw_req   (int_hw_req),
    .exc_req      (exc_req),
    .sel_exc_code (sel_exc_code)
  );

  // Held low during reset so an M-stage exception code cannot flush the
  // pipeline while the core is being reset.
  assign int_req = (int_hw_req | exc_req) & reset;

  // A faulting delay-slot instruction restarts at its branch.
  assign epc_entry = BD_in ? (PC_in - 32'd4) : PC_in;

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = HWInt;

    if (int_req) begin
      // Entry: any mtc0 this cycle belongs to the flushed instruction.
      sr_exl_d    = 1'b1;
      cause_exc_d = sel_exc_code;
      cause_bd_d  = BD_in;
      epc_d       = {epc_entry[31:2], 2'b00};
    end else begin
      if (EXL_clr) begin
        sr_exl_d = 1'b0;
      end
      if (we && (A == CP0_SR)) begin
        sr_im_d  = DIn[SR_IM_LO +: HWINT_W];
        sr_exl_d = DIn[SR_EXL];
        sr_ie_d  = DIn[SR_IE];
      end
      if (we && (A == CP0_EPC)) begin
        epc_d = {DIn[31:2], 2'b00};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_val                          = '0;
    sr_val[SR_IM_LO +: HWINT_W]     = sr_im_q;
    sr_val[SR_EXL]                  = sr_exl_q;
    sr_val[SR_IE]                   = sr_ie_q;
    cause_val                       = '0;
    cause_val[CAUSE_BD]             = cause_bd_q;
    cause_val[CAUSE_IP_LO +: HWINT_W] = cause_ip_q;
    cause_val[CAUSE_EXC_LO +: 5]    = cause_exc_q;
  end

  always_comb begin
    case (A)
      CP0_SR:    DOut = sr_val;
      CP0_CAUSE: DOut = cause_val;
      CP0_EPC:   DOut = epc_q;
      CP0_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

  assign EPC_out = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: a table of per-cycle vectors with
// hand-computed combinational outputs, plus hand-written reset sequences.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic        we;
  logic [31:0] DIn;
  logic [31:0] PC_in;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXL_clr;
  logic        int_req;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int checks = 0;
  int errors = 0;

  cp0_exc_unit #(.PRID(32'h4255_4141), .HWINT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .we         (we),
    .DIn        (DIn),
    .PC_in      (PC_in),
    .BD_in      (BD_in),
    .ExcCode_in (ExcCode_in),
    .HWInt      (HWInt),
    .EXL_clr    (EXL_clr),
    .int_req    (int_req),
    .EPC_out    (EPC_out),
    .DOut       (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  a;
    logic        we;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_int;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [4:0] a, input logic w,
                              input logic [31:0] din, input logic [31:0] pc, input logic bd,
                              input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                              input logic ei, input logic [31:0] ed, input logic [31:0] ee);
    vec_t v;
    v.name = name; v.a = a; v.we = w; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr;
    v.exp_int = ei; v.exp_dout = ed; v.exp_epc = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    A = v.a; we = v.we; DIn = v.din; PC_in = v.pc; BD_in = v.bd;
    ExcCode_in = v.exc; HWInt = v.hw; EXL_clr = v.clr;
  endtask

  task automatic idle();
    A = 5'd0; we = 1'b0; DIn = '0; PC_in = 32'h3000; BD_in = 1'b0;
    ExcCode_in = 5'd0; HWInt = '0; EXL_clr = 1'b0;
  endtask

  initial begin
    //            name          A   we din           pc            bd exc hw        clr int dout          epc
    vecs.push_back(mk("wr_sr",      12, 1, 32'h0000_0401, 32'h3000, 0, 0,  6'b000000, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("hwint_req",  12, 0, 32'h0,         32'h3000, 0, 0,  6'b000001, 0, 1, 32'h0000_0401, 32'h0));
    vecs.push_back(mk("int_cause",  13, 0, 32'h0,         32'h3000, 0, 4,  6'b000000, 0, 0, 32'h0000_0400, 32'h3000));
    vecs.push_back(mk("eret1",      12, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 1, 0, 32'h0000_0403, 32'h3000));
    vecs.push_back(mk("ri_bd_req",  13, 0, 32'h0,         32'h3010, 1, 10, 6'b000000, 0, 1, 32'h0,         32'h3000));
    vecs.push_back(mk("ri_cause",   13, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h8000_0028, 32'h300C));
    vecs.push_back(mk("eret2",      12, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 1, 0, 32'h0000_0403, 32'h300C));
    vecs.push_back(mk("prio_req",   13, 0, 32'h0,         32'h3020, 0, 12, 6'b000001, 0, 1, 32'h8000_0028, 32'h300C));
    vecs.push_back(mk("prio_cause", 13, 0, 32'h0,         32'h3000, 0, 4,  6'b000000, 0, 0, 32'h0000_0400, 32'h3020));
    vecs.push_back(mk("exl_masked", 12, 0, 32'h0,         32'h3000, 0, 4,  6'b000000, 1, 0, 32'h0000_0403, 32'h3020));
    vecs.push_back(mk("after_eret", 13, 0, 32'h0,         32'h3030, 0, 4,  6'b000000, 0, 1, 32'h0,         32'h3020));
    vecs.push_back(mk("eret3",      12, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 1, 0, 32'h0000_0403, 32'h3030));
    vecs.push_back(mk("mtc0_drop",  14, 1, 32'h0000_3007, 32'h3040, 0, 5,  6'b000000, 0, 1, 32'h3030,      32'h3030));
    vecs.push_back(mk("epc_entry",  14, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h3040,      32'h3040));
    vecs.push_back(mk("wr_epc",     14, 1, 32'h0000_3007, 32'h3000, 0, 0,  6'b000000, 0, 0, 32'h3040,      32'h3040));
    vecs.push_back(mk("rd_epc",     14, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h3004,      32'h3004));
    vecs.push_back(mk("rd_prid",    15, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h4255_4141, 32'h3004));
    vecs.push_back(mk("wr_cause",   13, 1, 32'hFFFF_FFFF, 32'h3000, 0, 0,  6'b000000, 0, 0, 32'h0000_0014, 32'h3004));
    vecs.push_back(mk("wr_undef",    7, 1, 32'hFFFF_FFFF, 32'h3000, 0, 0,  6'b000000, 0, 0, 32'h0,         32'h3004));
    vecs.push_back(mk("cause_kept", 13, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h0000_0014, 32'h3004));
    vecs.push_back(mk("eret4",      12, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 1, 0, 32'h0000_0403, 32'h3004));
    vecs.push_back(mk("wrap_req",   14, 0, 32'h0,         32'h0,    1, 12, 6'b000000, 0, 1, 32'h3004,      32'h3004));
    vecs.push_back(mk("wrap_epc",   14, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
    vecs.push_back(mk("wrap_cause", 13, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h8000_0030, 32'hFFFF_FFFC));
    vecs.push_back(mk("eret5",      12, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 1, 0, 32'h0000_0403, 32'hFFFF_FFFC));
    vecs.push_back(mk("im_masked",  12, 0, 32'h0,         32'h3000, 0, 0,  6'b000010, 0, 0, 32'h0000_0401, 32'hFFFF_FFFC));
    vecs.push_back(mk("ip_track",   13, 0, 32'h0,         32'h3000, 0, 0,  6'b000000, 0, 0, 32'h8000_0830, 32'hFFFF_FFFC));
    vecs.push_back(mk("wr_sr_ie0",  12, 1, 32'h0000_FC00, 32'h3000, 0, 0,  6'b000000, 0, 0, 32'h0000_0401, 32'hFFFF_FFFC));
    vecs.push_back(mk("ie_off",     12, 0, 32'h0,         32'h3000, 0, 0,  6'b111111, 0, 0, 32'h0000_FC00, 32'hFFFF_FFFC));

    // Power-on reset.
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("por_int_req", {31'd0, int_req}, 32'd0);
    check("por_epc_out", EPC_out, 32'd0);
    A = 5'd12; #1; check("por_sr", DOut, 32'd0);
    A = 5'd13; #1; check("por_cause", DOut, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check({vecs[i].name, ".int_req"}, {31'd0, int_req}, {31'd0, vecs[i].exp_int});
      check({vecs[i].name, ".dout"}, DOut, vecs[i].exp_dout);
      check({vecs[i].name, ".epc_out"}, EPC_out, vecs[i].exp_epc);
    end

    // Enter an exception at 0x3008 so EXL = 1 and EPC = 0x3008, then
    // pull reset mid-cycle while an exception code is still presented.
    @(negedge clk);
    idle();
    A = 5'd14; PC_in = 32'h3008; ExcCode_in = 5'd10;
    #1;
    check("pre_rst.int_req", {31'd0, int_req}, 32'd1);
    @(negedge clk);
    #1;
    check("pre_rst.epc_out", EPC_out, 32'h3008);
    check("pre_rst.int_masked", {31'd0, int_req}, 32'd0);
    A = 5'd12; #1;
    check("pre_rst.sr", DOut, 32'h0000_FC02);
    #1;
    reset = 1'b0;
    #1;
    check("rst.int_req", {31'd0, int_req}, 32'd0);
    check("rst.epc_out", EPC_out, 32'd0);
    check("rst.sr", DOut, 32'd0);
    A = 5'd13; #1; check("rst.cause", DOut, 32'd0);
    A = 5'd14; #1; check("rst.epc", DOut, 32'd0);

    // Release reset: EXL is now clear, so the still-present code requests.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst.int_req", {31'd0, int_req}, 32'd1);
    ExcCode_in = 5'd0;
    #1;
    check("post_rst.idle", {31'd0, int_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
